msp430_per_mailbox: RTL and testbench



---
 rtl/msp430_mbx_pkg.sv | 28 ++
 rtl/msp430_mbx_fifo.sv | 61 ++++++
 rtl/msp430_per_mailbox.sv | 124 ++++++++++++
 tb/tb_msp430_per_mailbox.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/msp430_mbx_pkg.sv
// Shared register map, bit positions and parameter checks for the MSP430
// peripheral-bus mailbox.
package msp430_mbx_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STAT   = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_RXDATA = 2'd3;

  localparam int CTRL_TX_IE    = 0;
  localparam int CTRL_RX_IE    = 1;
  localparam int CTRL_TX_FLUSH = 2;
  localparam int CTRL_RX_FLUSH = 3;

  localparam int STAT_TX_FULL    = 0;
  localparam int STAT_TX_EMPTY   = 1;
  localparam int STAT_RX_FULL    = 2;
  localparam int STAT_RX_EMPTY   = 3;
  localparam int STAT_TX_OVF     = 4;
  localparam int STAT_RX_UDF     = 5;
  localparam int STAT_RX_CNT_LSB = 8;

  // FIFO depth must be a power of two between 2 and 16 so rx_count fits STAT[12:8]
  function automatic bit depth_is_legal(input int depth);
    return (depth >= 2) && (depth <= 16) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/msp430_mbx_fifo.sv
// Small synchronous FIFO with show-ahead head output; flush overrides any
// same-cycle push or pop.
module msp430_mbx_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                       mclk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DW-1:0]              din,
  output logic [DW-1:0]              dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is not reset; the head is only observed while the FIFO is non-empty
  always_ff @(posedge mclk) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/msp430_per_mailbox.sv
// MSP430 peripheral-bus mailbox: CPU <-> 16-bit valid/ready stream bridge
// through a tx and an rx FIFO, with a registered level interrupt.
module msp430_per_mailbox
  import msp430_mbx_pkg::*;
#(
  parameter int          DW        = 16,
  parameter int          DEPTH     = 8,
  parameter logic [13:0] BASE_ADDR = 14'h00C0
) (
  input  logic          mclk,
  input  logic          reset_n,
  input  logic [13:0]   per_addr,
  input  logic [15:0]   per_din,
  input  logic [1:0]    per_we,
  input  logic          per_en,
  output logic [15:0]   per_dout,
  output logic          irq,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  output logic          rx_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (!depth_is_legal(DEPTH) || DW != 16 || BASE_ADDR[1:0] != 2'b00) begin : g_bad_param
    $error("msp430_per_mailbox: illegal DEPTH, DW or BASE_ADDR");
  end

  logic          sel, is_write;
  logic [1:0]    reg_sel;
  logic [15:0]   wdata;
  logic          ctrl_wr, stat_wr, tx_push, rx_rd;
  logic          tx_flush, rx_flush;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [DW-1:0] tx_head, rx_head;
  logic          tx_ie_reg, rx_ie_reg, tx_ovf_reg, rx_udf_reg, irq_reg;
  logic [15:0]   stat;

  assign sel      = per_en & (per_addr[13:2] == BASE_ADDR[13:2]);
  assign reg_sel  = per_addr[1:0];
  assign is_write = |per_we;
  assign wdata    = {per_we[1] ? per_din[15:8] : 8'h00, per_we[0] ? per_din[7:0] : 8'h00};

  assign ctrl_wr  = sel & is_write & (reg_sel == REG_CTRL);
  assign stat_wr  = sel & is_write & (reg_sel == REG_STAT);
  assign tx_push  = sel & is_write & (reg_sel == REG_TXDATA);
  assign rx_rd    = sel & ~is_write & (reg_sel == REG_RXDATA);
  assign tx_flush = ctrl_wr & wdata[CTRL_TX_FLUSH];
  assign rx_flush = ctrl_wr & wdata[CTRL_RX_FLUSH];

  msp430_mbx_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
    .mclk(mclk), .reset_n(reset_n),
    .push(tx_push), .pop(tx_valid & tx_ready), .flush(tx_flush),
    .din(wdata), .dout(tx_head),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  msp430_mbx_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
    .mclk(mclk), .reset_n(reset_n),
    .push(rx_valid & rx_ready), .pop(rx_rd), .flush(rx_flush),
    .din(rx_data), .dout(rx_head),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_empty ? '0 : tx_head;
  assign rx_ready = ~rx_full;
  assign irq      = irq_reg;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      tx_ie_reg  <= 1'b0;
      rx_ie_reg  <= 1'b0;
      tx_ovf_reg <= 1'b0;
      rx_udf_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        tx_ie_reg <= wdata[CTRL_TX_IE];
        rx_ie_reg <= wdata[CTRL_RX_IE];
      end
      if (tx_push && tx_full)                  tx_ovf_reg <= 1'b1;
      else if (stat_wr && wdata[STAT_TX_OVF])  tx_ovf_reg <= 1'b0;
      if (rx_rd && rx_empty)                   rx_udf_reg <= 1'b1;
      else if (stat_wr && wdata[STAT_RX_UDF])  rx_udf_reg <= 1'b0;
      irq_reg <= (tx_ie_reg & tx_empty) | (rx_ie_reg & ~rx_empty);
    end
  end

  always_comb begin
    stat = '0;
    stat[STAT_TX_FULL]  = tx_full;
    stat[STAT_TX_EMPTY] = tx_empty;
    stat[STAT_RX_FULL]  = rx_full;
    stat[STAT_RX_EMPTY] = rx_empty;
    stat[STAT_TX_OVF]   = tx_ovf_reg;
    stat[STAT_RX_UDF]   = rx_udf_reg;
    stat[STAT_RX_CNT_LSB +: 5] = 5'(rx_count);
  end

  always_comb begin
    per_dout = '0;
    if (sel && !is_write) begin
      case (reg_sel)
        REG_CTRL: begin
          per_dout[CTRL_TX_IE] = tx_ie_reg;
          per_dout[CTRL_RX_IE] = rx_ie_reg;
        end
        REG_STAT:   per_dout = stat;
        REG_RXDATA: per_dout = rx_empty ? 16'h0000 : rx_head;
        default:    per_dout = '0;
      endcase
    end
  end

  // The tx occupancy is only visible through full/empty; keep it bounded
  a_tx_count_bound: assert property (@(posedge mclk) disable iff (!reset_n)
    (tx_count <= CW'(DEPTH)) && (rx_count <= CW'(DEPTH)));

endmodule

// File: tb/tb_msp430_per_mailbox.sv
// Directed bench for msp430_per_mailbox: register map, both stream directions,
// irq and reset behaviour with hand-computed expectations.
module tb_msp430_per_mailbox;

  localparam logic [13:0] A_CTRL = 14'h00C0;
  localparam logic [13:0] A_STAT = 14'h00C1;
  localparam logic [13:0] A_TX   = 14'h00C2;
  localparam logic [13:0] A_RX   = 14'h00C3;

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic [1:0]  per_we = '0;
  logic        per_en = 1'b0;
  logic [15:0] per_dout;
  logic        irq;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] rd;

  msp430_per_mailbox #(.DW(16), .DEPTH(8), .BASE_ADDR(14'h00C0)) dut (
    .mclk(mclk), .reset_n(reset_n),
    .per_addr(per_addr), .per_din(per_din), .per_we(per_we), .per_en(per_en),
    .per_dout(per_dout), .irq(irq),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic bus_write(input logic [13:0] addr, input logic [15:0] data, input logic [1:0] we);
    per_addr = addr; per_din = data; per_we = we; per_en = 1'b1;
    tick();
    per_en = 1'b0; per_we = 2'b00; per_din = '0;
    $display("  wr addr=%h data=%h we=%b", addr, data, we);
  endtask

  task automatic bus_read(input logic [13:0] addr, output logic [15:0] data);
    per_addr = addr; per_we = 2'b00; per_en = 1'b1;
    #1;
    data = per_dout;
    tick();
    per_en = 1'b0;
    $display("  rd addr=%h data=%h", addr, data);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    n_cmp++; if (per_dout !== 16'h0000) begin n_fail++; $display("FAIL reset_dout: got %h want 0000", per_dout); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_cmp++; if (tx_data !== 16'h0000) begin n_fail++; $display("FAIL reset_tx_data: got %h want 0000", tx_data); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 16'h000A) begin n_fail++; $display("FAIL reset_stat: got %h want 000A", rd); end
    bus_read(14'h00C4, rd);
    n_cmp++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL unselected_read: got %h want 0000", rd); end
  endtask

  task automatic test_tx_single();
    bus_write(A_TX, 16'hA5C3, 2'b11);
    n_cmp++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL tx1_valid: got %b want 1", tx_valid); end
    n_cmp++; if (tx_data !== 16'hA5C3) begin n_fail++; $display("FAIL tx1_data: got %h want A5C3", tx_data); end
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 16'h0008) begin n_fail++; $display("FAIL tx1_stat: got %h want 0008", rd); end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx1_drained: got %b want 0", tx_valid); end
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 16'h000A) begin n_fail++; $display("FAIL tx1_stat_empty: got %h want 000A", rd); end
    // Low-lane-only write: upper byte must arrive as zero
    bus_write(A_TX, 16'hBEEF, 2'b01);
    n_cmp++; if (tx_data !== 16'h00EF) begin n_fail++; $display("FAIL tx_byte_mask: got %h want 00EF", tx_data); end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic test_tx_overflow();
    for (int i = 1; i <= 9; i++) bus_write(A_TX, 16'(i), 2'b11);
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 16'h0019) begin n_fail++; $display("FAIL tx_ovf_stat: got %h want 0019", rd); end
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== 16'(i)) begin
        n_fail++; $display("FAIL tx_drain_%0d: got valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, 16'(i));
      end
      tick();
    end
    tx_ready = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drain_end: got %b want 0", tx_valid); end
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 16'h001A) begin n_fail++; $display("FAIL tx_ovf_sticky: got %h want 001A", rd); end
    bus_write(A_STAT, 16'h0010, 2'b11);
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 16'h000A) begin n_fail++; $display("FAIL tx_ovf_w1c: got %h want 000A", rd); end
  endtask

  task automatic test_rx();
    rx_valid = 1'b1; rx_data = 16'h1111;
    tick();
    rx_data = 16'h2222;
    tick();
    rx_valid = 1'b0; rx_data = '0;
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 16'h0202) begin n_fail++; $display("FAIL rx_count2: got %h want 0202", rd); end
    bus_read(A_RX, rd);
    n_cmp++; if (rd !== 16'h1111) begin n_fail++; $display("FAIL rx_pop1: got %h want 1111", rd); end
    bus_read(A_RX, rd);
    n_cmp++; if (rd !== 16'h2222) begin n_fail++; $display("FAIL rx_pop2: got %h want 2222", rd); end
    bus_read(A_RX, rd);
    n_cmp++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL rx_pop_empty: got %h want 0000", rd); end
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 16'h002A) begin n_fail++; $display("FAIL rx_udf_stat: got %h want 002A", rd); end
    bus_write(A_STAT, 16'h0020, 2'b11);
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 16'h000A) begin n_fail++; $display("FAIL rx_udf_w1c: got %h want 000A", rd); end
  endtask

  task automatic test_irq();
    bus_write(A_CTRL, 16'h0002, 2'b11);
    bus_read(A_CTRL, rd);
    n_cmp++; if (rd !== 16'h0002) begin n_fail++; $display("FAIL ctrl_read: got %h want 0002", rd); end
    rx_valid = 1'b1; rx_data = 16'h3333;
    tick();
    rx_valid = 1'b0;
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_not_yet: got %b want 0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rx: got %b want 1", irq); end
    bus_write(A_CTRL, 16'h000A, 2'b11);
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 16'h000A) begin n_fail++; $display("FAIL rx_flush_stat: got %h want 000A", rd); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_flush: got %b want 0", irq); end
    bus_read(A_CTRL, rd);
    n_cmp++; if (rd !== 16'h0002) begin n_fail++; $display("FAIL flush_self_clear: got %h want 0002", rd); end
    bus_write(A_CTRL, 16'h0001, 2'b11);
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_tx_empty: got %b want 1", irq); end
    bus_write(A_CTRL, 16'h0000, 2'b11);
    tick();
  endtask

  task automatic test_back_to_back();
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 16'h0100 + 16'(i);
      tick();
    end
    n_cmp++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_full_ready: got %b want 0", rx_ready); end
    rx_data = 16'hDEAD;
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 16'h0806) begin n_fail++; $display("FAIL rx_full_stat: got %h want 0806", rd); end
    // Pop and offered push in the same cycle while full: push is dropped
    bus_read(A_RX, rd);
    rx_valid = 1'b0;
    n_cmp++; if (rd !== 16'h0100) begin n_fail++; $display("FAIL rx_full_pop: got %h want 0100", rd); end
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 16'h0702) begin n_fail++; $display("FAIL rx_count7: got %h want 0702", rd); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready_again: got %b want 1", rx_ready); end
    bus_write(A_CTRL, 16'h0002, 2'b11);
    bus_write(A_TX, 16'h5555, 2'b11);
    tick();
    n_cmp++; if (irq !== 1'b1 || tx_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset: got irq=%b tx_valid=%b want 1 1", irq, tx_valid); end
    rx_valid = 1'b1; rx_data = 16'h7777;
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (tx_valid !== 1'b0 || tx_data !== 16'h0000) begin n_fail++; $display("FAIL async_reset_tx: got valid=%b data=%h want 0 0000", tx_valid, tx_data); end
    n_cmp++; if (irq !== 1'b0 || rx_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_irq_ready: got irq=%b rx_ready=%b want 0 1", irq, rx_ready); end
    tick(); tick();
    rx_valid = 1'b0;
    reset_n = 1'b1;
    bus_read(A_STAT, rd);
    n_cmp++; if (rd !== 16'h000A) begin n_fail++; $display("FAIL post_reset_stat: got %h want 000A", rd); end
    bus_read(A_CTRL, rd);
    n_cmp++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL post_reset_ctrl: got %h want 0000", rd); end
  endtask

  initial begin
    #1;
    test_reset();
    test_tx_single();
    test_tx_overflow();
    test_rx();
    test_irq();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
